// File: rtl/control_strobe_gen_pkg.sv
// control_strobe_gen_pkg: shared FSM encoding, phase-field width and period clamp
// for the strobe generator and its phase comparators.
package control_strobe_gen_pkg;

    localparam int NB_PHASE = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // A requested period of 0 behaves as 1 so the counter always has a wrap point.
    function automatic logic [31:0] clamp_period(input logic [31:0] p);
        return (p == '0) ? 32'd1 : p;
    endfunction

endpackage

// File: rtl/control_strobe_gen_phase_match.sv
// control_phase_match: registered one-cycle strobe when the shared counter
// equals this channel's phase and the strobe is qualified.
module control_phase_match
    import control_strobe_gen_pkg::*;
#(
    parameter int NB_PERIOD = NB_PHASE
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic [NB_PERIOD-1:0] i_cont,
    input  logic [NB_PERIOD-1:0] i_phase,
    input  logic                 i_qualify,
    output logic                 o_strobe
);

    logic r_strobe;

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) r_strobe <= 1'b0;
        else         r_strobe <= i_qualify && (i_cont == i_phase);
    end

    assign o_strobe = r_strobe;

endmodule

// File: rtl/control_strobe_gen.sv
// control_strobe_gen: modulo-P sample strobe plus N_CH phase strobes, with period
// and phases shadow-registered and reloaded only at wrap, first load or sync.
module control_strobe_gen
    import control_strobe_gen_pkg::*;
#(
    parameter int NB_PERIOD       = NB_PHASE,
    parameter int N_CH            = 2,
    parameter bit HOLD_ON_DISABLE = 1'b0
) (
    input  logic                      clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic                      i_sync,
    input  logic [NB_PERIOD-1:0]      i_period,
    input  logic [N_CH*NB_PERIOD-1:0] i_phase,
    output logic                      o_valid,
    output logic [N_CH-1:0]           o_ch_valid,
    output logic [NB_PERIOD-1:0]      o_count,
    output logic                      o_busy
);

    state_t                    r_state;
    logic [NB_PERIOD-1:0]      r_cont;
    logic [NB_PERIOD-1:0]      r_period;
    logic [N_CH*NB_PERIOD-1:0] r_phase;

    state_t               w_state_next;
    logic [NB_PERIOD-1:0] w_cont_next;
    logic                 w_load;
    logic                 w_wrap;
    logic                 w_qualify;

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_cont_next  = r_cont;
        w_load       = 1'b0;
        w_wrap       = (r_cont == r_period - NB_PERIOD'(1));
        // Sync suppresses strobes on its own edge; only a running, enabled cycle fires.
        w_qualify    = (r_state == ST_RUN) && i_enable && !i_sync;
        if (i_sync) begin
            w_state_next = i_enable ? ST_RUN : ST_IDLE;
            w_cont_next  = '0;
            w_load       = 1'b1;
        end else if (r_state == ST_IDLE) begin
            w_state_next = i_enable ? ST_RUN : ST_IDLE;
            w_cont_next  = '0;
            w_load       = i_enable;
        end else if (i_enable) begin
            w_cont_next  = w_wrap ? '0 : r_cont + NB_PERIOD'(1);
            w_load       = w_wrap;
        end else if (HOLD_ON_DISABLE == 1'b0) begin
            w_state_next = ST_IDLE;
            w_cont_next  = '0;
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            r_cont   <= '0;
            r_period <= '1;
            r_phase  <= '0;
        end else begin
            r_cont <= w_cont_next;
            if (w_load) begin
                r_period <= NB_PERIOD'(clamp_period(32'(i_period)));
                r_phase  <= i_phase;
            end
        end
    end

    // The sample strobe is simply a phase-0 comparator.
    control_phase_match #(.NB_PERIOD(NB_PERIOD)) u_valid (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_cont    (r_cont),
        .i_phase   (NB_PERIOD'(0)),
        .i_qualify (w_qualify),
        .o_strobe  (o_valid)
    );

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        control_phase_match #(.NB_PERIOD(NB_PERIOD)) u_match (
            .clock     (clock),
            .i_reset   (i_reset),
            .i_cont    (r_cont),
            .i_phase   (r_phase[c*NB_PERIOD +: NB_PERIOD]),
            .i_qualify (w_qualify),
            .o_strobe  (o_ch_valid[c])
        );
    end

    assign o_count = r_cont;
    assign o_busy  = (r_state == ST_RUN);

endmodule

// File: tb/tb_control_strobe_gen.sv
// tb_control_strobe_gen: clear-mode and hold-mode instances share random and
// directed stimulus; a per-cycle expectation queue is checked by a monitor.
module tb_control_strobe_gen;

    localparam int NB  = 4;
    localparam int NCH = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              i_reset;
    logic              i_enable;
    logic              i_sync;
    logic [NB-1:0]     i_period;
    logic [NCH*NB-1:0] i_phase;

    logic [1:0]           o_valid;
    logic [1:0][NCH-1:0]  o_ch;
    logic [1:0][NB-1:0]   o_count;
    logic [1:0]           o_busy;

    control_strobe_gen #(.NB_PERIOD(NB), .N_CH(NCH), .HOLD_ON_DISABLE(1'b0)) dut0 (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_sync(i_sync),
        .i_period(i_period), .i_phase(i_phase), .o_valid(o_valid[0]),
        .o_ch_valid(o_ch[0]), .o_count(o_count[0]), .o_busy(o_busy[0])
    );

    control_strobe_gen #(.NB_PERIOD(NB), .N_CH(NCH), .HOLD_ON_DISABLE(1'b1)) dut1 (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_sync(i_sync),
        .i_period(i_period), .i_phase(i_phase), .o_valid(o_valid[1]),
        .o_ch_valid(o_ch[1]), .o_count(o_count[1]), .o_busy(o_busy[1])
    );

    typedef struct packed {
        logic           v;
        logic [NCH-1:0] ch;
        logic [NB-1:0]  cnt;
        logic           busy;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;
    bit   started = 1'b0;

    // Reference model: one entry per instance (0 = clear on disable, 1 = hold).
    int m_cnt [2];
    int m_per [2];
    int m_ph  [2][NCH];
    bit m_run [2];

    task automatic model_load(input int d, input int p, input logic [NCH*NB-1:0] ph);
        m_per[d] = (p == 0) ? 1 : p;
        for (int c = 0; c < NCH; c++) m_ph[d][c] = int'(ph[c*NB +: NB]);
    endtask

    task automatic model_step(input bit rst, input bit en, input bit sync,
                              input int p, input logic [NCH*NB-1:0] ph);
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            e = '0;
            if (rst) begin
                m_run[d] = 1'b0;
                m_cnt[d] = 0;
                m_per[d] = (1 << NB) - 1;
                for (int c = 0; c < NCH; c++) m_ph[d][c] = 0;
            end else if (sync) begin
                m_cnt[d] = 0;
                model_load(d, p, ph);
                m_run[d] = en;
            end else if (!m_run[d]) begin
                if (en) begin
                    model_load(d, p, ph);
                    m_run[d] = 1'b1;
                end
                m_cnt[d] = 0;
            end else if (en) begin
                e.v = (m_cnt[d] == 0);
                for (int c = 0; c < NCH; c++) e.ch[c] = (m_cnt[d] == m_ph[d][c]);
                m_cnt[d] = (m_cnt[d] + 1) % m_per[d];
                if (m_cnt[d] == 0) model_load(d, p, ph);
            end else if (d == 0) begin
                m_cnt[d] = 0;
                m_run[d] = 1'b0;
            end
            e.cnt  = m_cnt[d][NB-1:0];
            e.busy = m_run[d];
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic cyc(input bit rst, input bit en, input bit sync,
                       input int p, input logic [NCH*NB-1:0] ph);
        @(negedge clock);
        i_reset  = rst;
        i_enable = en;
        i_sync   = sync;
        i_period = p[NB-1:0];
        i_phase  = ph;
        model_step(rst, en, sync, p, ph);
        started  = 1'b1;
    endtask

    task automatic async_rst();
        @(negedge clock);
        #2;
        i_reset = 1'b1;
        #1;
        total++;
        if ({o_valid, o_ch, o_count, o_busy} !== '0) begin
            bad++;
            $display("FAIL async_reset got v=%b ch=%b cnt=%h busy=%b want all zero",
                     o_valid, o_ch, o_count, o_busy);
        end
        model_step(1'b1, i_enable, i_sync, int'(i_period), i_phase);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (started) begin
                for (int d = 0; d < 2; d++) begin
                    exp_t e, got;
                    got = '{o_valid[d], o_ch[d], o_count[d], o_busy[d]};
                    total++;
                    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                        bad++;
                        $display("FAIL dut%0d no_expectation at %0t", d, $time);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        if (got !== e) begin
                            bad++;
                            $display("FAIL dut%0d cycle_out t=%0t got v=%b ch=%b cnt=%0d busy=%b want v=%b ch=%b cnt=%0d busy=%b",
                                     d, $time, got.v, got.ch, got.cnt, got.busy, e.v, e.ch, e.cnt, e.busy);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int p;
        logic [NCH*NB-1:0] ph;
        bit en;
        i_reset = 1'b1; i_enable = 1'b0; i_sync = 1'b0; i_period = '0; i_phase = '0;
        cyc(1, 0, 0, 4, 8'h20);
        // Basic P=4, phases {0,2}
        for (int k = 0; k < 14; k++) cyc(0, 1, 0, 4, 8'h20);
        // Period change mid-period: ignored until wrap
        for (int k = 0; k < 12; k++) cyc(0, 1, 0, 3, 8'h20);
        // Period 0 and 1 with a phase-1 channel that must never fire
        for (int k = 0; k < 6; k++) cyc(0, 1, 0, 0, 8'h10);
        for (int k = 0; k < 6; k++) cyc(0, 1, 0, 1, 8'h10);
        // Disable for 2 cycles mid-period (clear vs hold)
        cyc(0, 1, 1, 4, 8'h20);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 4, 8'h20);
        cyc(0, 0, 0, 4, 8'h20);
        cyc(0, 0, 0, 4, 8'h20);
        for (int k = 0; k < 8; k++) cyc(0, 1, 0, 4, 8'h20);
        // Sync pulse mid-period
        cyc(0, 1, 0, 4, 8'h20);
        cyc(0, 1, 1, 4, 8'h20);
        for (int k = 0; k < 6; k++) cyc(0, 1, 0, 4, 8'h20);
        // Asynchronous reset between edges, then restart
        async_rst();
        for (int k = 0; k < 8; k++) cyc(0, 1, 0, 4, 8'h20);
        // Randomized traffic, including max period and out-of-range phases
        p  = 5;
        ph = 8'h31;
        for (int k = 0; k < 700; k++) begin
            if ($urandom % 10 == 0) p  = int'($urandom_range(0, 15));
            if ($urandom % 10 == 0) ph = NCH*NB'($urandom);
            if ($urandom % 200 == 0) async_rst();
            en = ($urandom % 8) != 0;
            cyc(0, en, ($urandom % 40) == 0, p, ph);
        end
        @(posedge clock);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
